// File: rtl/mem_stage_lsu_if.sv
// Data-bus bundle between the MEM-stage load/store unit (master) and the data memory or bus fabric (slave).
interface mem_stage_lsu_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_sel;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: big-endian byte lanes, IDLE/BUSY/DONE bus handshake, stall and flush handling.
// Optional LSU_TIMEOUT_EN macro adds an 8-bit BUSY watchdog that aborts the access and pulses bus_err.
module mem_stage_lsu (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          mem_wdata,
  input  logic [4:0]           mem_wd,
  input  logic                 mem_wreg,
  input  logic [7:0]           mem_aluop,
  input  logic [31:0]          mem_mem_addr,
  input  logic [31:0]          mem_reg2,
  input  logic [5:0]           stall,
  input  logic                 flush,
  mem_stage_lsu_if.master      bus,
  output logic [31:0]          wb_wdata,
  output logic [4:0]           wb_wd,
  output logic                 wb_wreg,
  output logic                 stallreq_mem,
  output logic                 adel,
  output logic                 ades,
  output logic                 bus_err
);

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  function automatic logic [3:0] lane_sel(input logic [7:0] op, input logic [1:0] a);
    logic [3:0] s;
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: begin
        case (a)
          2'b00:   s = 4'b1000;
          2'b01:   s = 4'b0100;
          2'b10:   s = 4'b0010;
          default: s = 4'b0001;
        endcase
      end
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: s = a[1] ? 4'b0011 : 4'b1100;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] store_data(input logic [7:0] op, input logic [31:0] r);
    logic [31:0] d;
    case (op)
      EXE_SB_OP: d = {4{r[7:0]}};
      EXE_SH_OP: d = {2{r[15:0]}};
      default:   d = r;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] load_extend(input logic [7:0] op, input logic [1:0] a,
                                              input logic [31:0] d);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] s;
    case (a)
      2'b00:   b = d[31:24];
      2'b01:   b = d[23:16];
      2'b10:   b = d[15:8];
      default: b = d[7:0];
    endcase
    h = a[1] ? d[15:0] : d[31:16];
    case (op)
      EXE_LB_OP:  s = 32'(b);
      EXE_LBU_OP: s = {24'd0, b};
      EXE_LH_OP:  s = 32'(h);
      EXE_LHU_OP: s = {16'd0, h};
      default:    s = d;
    endcase
    return s;
  endfunction

  state_t      state, state_nxt;
  logic        is_load, is_store, is_half, is_word, misalign, valid_acc;
  logic        req_p1, we_p1;
  logic [31:0] addr_p1, wdata_p1, load_data_p1;
  logic [3:0]  sel_p1;
  logic        flushed_p1, drop_p1;
  logic        timeout_hit;
  logic        unused_stall;

  assign unused_stall = ^{stall[5], stall[3:0]};

  always_comb begin
    is_load   = mem_aluop inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP};
    is_store  = mem_aluop inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
    is_half   = mem_aluop inside {EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP};
    is_word   = mem_aluop inside {EXE_LW_OP, EXE_SW_OP};
    misalign  = (is_half && mem_mem_addr[0]) || (is_word && (mem_mem_addr[1:0] != 2'b00));
    valid_acc = (is_load || is_store) && !misalign;
  end

  assign adel = is_load && misalign;
  assign ades = is_store && misalign;

  // drop_p1 blocks a restart of an access that was flushed or timed out until the pipeline moves on
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (valid_acc && !flush && !drop_p1) state_nxt = BUSY;
      BUSY: begin
        if (bus.bus_ack) state_nxt = (flush || flushed_p1) ? IDLE : DONE;
        else if (timeout_hit) state_nxt = IDLE;
      end
      DONE: if (flush || !stall[4]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wb_wd        = mem_wd;
    wb_wdata     = mem_wdata;
    wb_wreg      = mem_wreg;
    stallreq_mem = 1'b0;
    if (is_load || is_store) begin
      wb_wreg = 1'b0;
      if (state == DONE && is_load) begin
        wb_wdata = load_data_p1;
        wb_wreg  = mem_wreg;
      end
    end
    if (flush) wb_wreg = 1'b0;
    if (state == BUSY) stallreq_mem = 1'b1;
    else if (state == IDLE) stallreq_mem = valid_acc && !drop_p1;
  end

  // p1: bus request registers, captured load data and abort bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      req_p1       <= 1'b0;
      we_p1        <= 1'b0;
      addr_p1      <= 32'd0;
      sel_p1       <= 4'd0;
      wdata_p1     <= 32'd0;
      load_data_p1 <= 32'd0;
      flushed_p1   <= 1'b0;
      drop_p1      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt == BUSY) begin
        req_p1   <= 1'b1;
        we_p1    <= is_store;
        addr_p1  <= {mem_mem_addr[31:2], 2'b00};
        sel_p1   <= lane_sel(mem_aluop, mem_mem_addr[1:0]);
        wdata_p1 <= store_data(mem_aluop, mem_reg2);
      end else if (state == BUSY && state_nxt != BUSY) begin
        req_p1   <= 1'b0;
        we_p1    <= 1'b0;
        addr_p1  <= 32'd0;
        sel_p1   <= 4'd0;
        wdata_p1 <= 32'd0;
      end
      if (state == BUSY && state_nxt == DONE)
        load_data_p1 <= load_extend(mem_aluop, mem_mem_addr[1:0], bus.bus_rdata);
      flushed_p1 <= (state == BUSY) && (state_nxt == BUSY) && (flushed_p1 || flush);
      if (state == BUSY && state_nxt == IDLE) drop_p1 <= 1'b1;
      else if (state == IDLE && !stall[4]) drop_p1 <= 1'b0;
    end
  end

  assign bus.bus_req   = req_p1;
  assign bus.bus_we    = we_p1;
  assign bus.bus_addr  = addr_p1;
  assign bus.bus_sel   = sel_p1;
  assign bus.bus_wdata = wdata_p1;

`ifdef LSU_TIMEOUT_EN
  logic [7:0] tmo_cnt_p1;
  logic       bus_err_p1;

  assign timeout_hit = (tmo_cnt_p1 == 8'hFF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_p1 <= 8'd0;
      bus_err_p1 <= 1'b0;
    end else begin
      bus_err_p1 <= (state == BUSY) && !bus.bus_ack && timeout_hit;
      tmo_cnt_p1 <= (state == BUSY && state_nxt == BUSY) ? tmo_cnt_p1 + 8'd1 : 8'd0;
    end
  end

  assign bus_err = bus_err_p1;
`else
  assign timeout_hit = 1'b0;
  assign bus_err     = 1'b0;
`endif

endmodule
